// File: rtl/vec_mag_arbiter.sv
// vec_mag_arbiter: round-robin, packet-locking arbiter for a shared magnitude core.
// Ports: aclk/aresetn/arb_clear_i, s_axis_* (N_REQ requesters), core_s_axis_* (to core),
//   core_m_axis_* (from core), m_axis_* (results out), arb_busy_o, arb_orphan_o,
//   arb_grant_cnt_o (only with VEC_MAG_ARB_STATS_EN defined).
module vec_mag_arbiter #(
  parameter int COORD_WIDTH = 8,
  parameter int N_REQ       = 4,
  parameter int TAG_DEPTH   = 8
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         arb_clear_i,
  input  logic [N_REQ*4*COORD_WIDTH-1:0] s_axis_tdata,
  input  logic [N_REQ-1:0]             s_axis_tvalid,
  input  logic [N_REQ-1:0]             s_axis_tlast,
  output logic [N_REQ-1:0]             s_axis_tready,
  output logic [4*COORD_WIDTH-1:0]     core_s_axis_tdata,
  output logic                         core_s_axis_tvalid,
  output logic                         core_s_axis_tlast,
  input  logic                         core_s_axis_tready,
  input  logic [4*COORD_WIDTH-1:0]     core_m_axis_tdata,
  input  logic                         core_m_axis_tvalid,
  output logic                         core_m_axis_tready,
  output logic [4*COORD_WIDTH-1:0]     m_axis_tdata,
  output logic [N_REQ-1:0]             m_axis_tvalid,
  input  logic [N_REQ-1:0]             m_axis_tready,
  output logic [N_REQ-1:0]             m_axis_tlast,
  output logic                         arb_busy_o,
  output logic                         arb_orphan_o
`ifdef VEC_MAG_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0]          arb_grant_cnt_o
`endif
);

  localparam int BW = 4 * COORD_WIDTH;
  localparam int IW = $clog2(N_REQ);
  localparam int AW = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] lk_q, lk_d;
  logic [IW-1:0] tag_mem [TAG_DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic [IW-1:0] sel, head, cand;
  logic          found;
  logic          rst, hold_q, blk;
  logic          full, empty;
  logic          push, pop, drop;
  logic          orphan_q;
  int            idx;

  assign rst   = !aresetn || arb_clear_i;
  // outputs stay quiet in the clear cycle and the one after it
  assign blk   = rst || hold_q;
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = tag_mem[rd_q[AW-1:0]];

  assign push = core_s_axis_tvalid && core_s_axis_tready;
  assign pop  = core_m_axis_tvalid && core_m_axis_tready && !empty;
  assign drop = core_m_axis_tvalid && core_m_axis_tready && empty;

  // round-robin pick: scanning downward so the lowest offset wins
  always_comb begin
    sel   = lk_q;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    if (state_q == LOCKED) begin
      found = 1'b1;
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        idx = int'(rr_q) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        cand = IW'(idx);
        if (s_axis_tvalid[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      lk_q     <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      orphan_q <= 1'b0;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      lk_q     <= lk_d;
      hold_q   <= 1'b0;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (drop) orphan_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) tag_mem[wr_q[AW-1:0]] <= sel;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lk_d    = lk_q;
    if (push) begin
      if (core_s_axis_tlast) begin
        state_d = IDLE;
        rr_d    = (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
      end else begin
        state_d = LOCKED;
        lk_d    = sel;
      end
    end
  end

  always_comb begin
    core_s_axis_tdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel == IW'(k)) core_s_axis_tdata = s_axis_tdata[k*BW +: BW];
    end
    core_s_axis_tlast  = s_axis_tlast[sel];
    core_s_axis_tvalid = found && s_axis_tvalid[sel] && !full && !blk;
    s_axis_tready      = '0;
    if (found && !blk) s_axis_tready[sel] = core_s_axis_tready && !full;
    m_axis_tvalid      = '0;
    core_m_axis_tready = 1'b0;
    if (!blk) begin
      if (empty) begin
        // nobody owns this result: swallow it
        core_m_axis_tready = 1'b1;
      end else begin
        m_axis_tvalid[head] = core_m_axis_tvalid;
        core_m_axis_tready  = m_axis_tready[head];
      end
    end
  end

  assign m_axis_tdata = core_m_axis_tdata;
  assign m_axis_tlast = '1;
  assign arb_busy_o   = (state_q == LOCKED) || !empty;
  assign arb_orphan_o = orphan_q;

`ifdef VEC_MAG_ARB_STATS_EN
  logic [31:0] cnt_q [N_REQ];

  always_ff @(posedge aclk) begin
    if (rst) begin
      for (int k = 0; k < N_REQ; k++) cnt_q[k] <= '0;
    end else if (push) begin
      cnt_q[sel] <= cnt_q[sel] + 32'd1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign arb_grant_cnt_o[g*32 +: 32] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_vec_mag_arbiter.sv
// tb_vec_mag_arbiter: table vectors, directed sequences and random traffic
// checked against a queue-based arbiter model.
module tb_vec_mag_arbiter;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int BW = 32;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            arb_clear_i = 1'b0;
  logic [N*BW-1:0] s_axis_tdata;
  logic [N-1:0]    s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [BW-1:0]   core_s_axis_tdata;
  logic            core_s_axis_tvalid, core_s_axis_tlast, core_s_axis_tready;
  logic [BW-1:0]   core_m_axis_tdata;
  logic            core_m_axis_tvalid, core_m_axis_tready;
  logic [BW-1:0]   m_axis_tdata;
  logic [N-1:0]    m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic            arb_busy_o, arb_orphan_o;
`ifdef VEC_MAG_ARB_STATS_EN
  logic [N*32-1:0] arb_grant_cnt_o;
`endif

  int n_run = 0;
  int n_fail = 0;

  int m_q[$];
  bit m_locked;
  int m_lk;
  int m_rr;
  bit m_orph;

  always #5 aclk = ~aclk;

  vec_mag_arbiter #(.COORD_WIDTH(8), .N_REQ(N), .TAG_DEPTH(D)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .arb_clear_i(arb_clear_i),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .core_s_axis_tdata(core_s_axis_tdata),
    .core_s_axis_tvalid(core_s_axis_tvalid),
    .core_s_axis_tlast(core_s_axis_tlast),
    .core_s_axis_tready(core_s_axis_tready),
    .core_m_axis_tdata(core_m_axis_tdata),
    .core_m_axis_tvalid(core_m_axis_tvalid),
    .core_m_axis_tready(core_m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .arb_busy_o(arb_busy_o),
    .arb_orphan_o(arb_orphan_o)
`ifdef VEC_MAG_ARB_STATS_EN
    ,
    .arb_grant_cnt_o(arb_grant_cnt_o)
`endif
  );

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    s_axis_tvalid      = '0;
    s_axis_tlast       = '1;
    core_s_axis_tready = 1'b0;
    core_m_axis_tvalid = 1'b0;
    core_m_axis_tdata  = 32'h0;
    m_axis_tready      = '0;
    for (int i = 0; i < N; i++)
      s_axis_tdata[i*BW +: BW] = 32'hC0DE_0000 + i * 32'h1111;
  endtask

  task automatic do_reset(bit use_clear);
    @(negedge aclk);
    if (use_clear) arb_clear_i = 1'b1;
    else aresetn = 1'b0;
    s_axis_tvalid      = '1;
    core_s_axis_tready = 1'b1;
    core_m_axis_tvalid = 1'b0;
    m_axis_tready      = '1;
    #1;
    chk("rst_quiet", {s_axis_tready, m_axis_tvalid, core_s_axis_tvalid}, 0);
    @(negedge aclk);
    aresetn     = 1'b1;
    arb_clear_i = 1'b0;
    #1;
    chk("post_rst_quiet", {s_axis_tready, m_axis_tvalid, core_s_axis_tvalid}, 0);
    chk("post_rst_state", {arb_busy_o, arb_orphan_o}, 0);
    @(negedge aclk);
    idle_inputs();
    m_q.delete();
    m_locked = 0;
    m_lk     = 0;
    m_rr     = 0;
    m_orph   = 0;
  endtask

  // compare one cycle against the model, then let the edge happen
  task automatic step_check(string nm);
    int          sel;
    bit          found, full, empty, push, pop;
    logic [N-1:0] er, emv;
    logic        ecv, ecmr;
    full  = (m_q.size() == D);
    empty = (m_q.size() == 0);
    found = 0;
    sel   = 0;
    if (m_locked) begin
      sel   = m_lk;
      found = 1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!found && s_axis_tvalid[(m_rr + k) % N]) begin
          sel   = (m_rr + k) % N;
          found = 1;
        end
      end
    end
    er  = '0;
    ecv = 1'b0;
    if (found) begin
      ecv     = s_axis_tvalid[sel] && !full;
      er[sel] = core_s_axis_tready && !full;
    end
    emv  = '0;
    ecmr = 1'b1;
    if (!empty) begin
      emv[m_q[0]] = core_m_axis_tvalid;
      ecmr        = m_axis_tready[m_q[0]];
    end
    #1;
    chk(nm, {s_axis_tready, core_s_axis_tvalid, m_axis_tvalid,
             core_m_axis_tready, arb_busy_o, arb_orphan_o},
        {er, ecv, emv, ecmr, m_locked || !empty, m_orph});
    if (ecv)
      chk({nm, "_fwd"}, {core_s_axis_tlast, core_s_axis_tdata},
          {s_axis_tlast[sel], s_axis_tdata[sel*BW +: BW]});
    if (core_m_axis_tvalid && !empty)
      chk({nm, "_ret"}, m_axis_tdata, core_m_axis_tdata);
    push = ecv && core_s_axis_tready;
    pop  = core_m_axis_tvalid && ecmr;
    @(posedge aclk);
    if (pop) begin
      if (empty) m_orph = 1;
      else void'(m_q.pop_front());
    end
    if (push) begin
      m_q.push_back(sel);
      if (s_axis_tlast[sel]) begin
        m_locked = 0;
        m_rr     = (sel + 1) % N;
      end else begin
        m_locked = 1;
        m_lk     = sel;
      end
    end
    @(negedge aclk);
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic         cr;
    logic [N-1:0] er;
    logic         ecv;
  } vec_t;

  vec_t tbl[8];
  int   heads[6];
  int   acc;

  initial begin
    tbl[0] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[1] = '{4'b1010, 1'b1, 4'b0010, 1'b1};
    tbl[2] = '{4'b1010, 1'b1, 4'b1000, 1'b1};
    tbl[3] = '{4'b0001, 1'b0, 4'b0000, 1'b1};
    tbl[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1};
    tbl[5] = '{4'b0001, 1'b1, 4'b0001, 1'b1};
    tbl[6] = '{4'b1100, 1'b1, 4'b0100, 1'b1};
    tbl[7] = '{4'b0111, 1'b1, 4'b0001, 1'b1};
    heads  = '{1, 3, 0, 0, 2, 0};

    idle_inputs();
    do_reset(0);

    for (int i = 0; i < 8; i++) begin
      s_axis_tvalid      = tbl[i].v;
      core_s_axis_tready = tbl[i].cr;
      #1;
      chk($sformatf("tbl%0d", i), {s_axis_tready, core_s_axis_tvalid},
          {tbl[i].er, tbl[i].ecv});
      step_check("tbl_model");
    end
    idle_inputs();
    core_m_axis_tvalid = 1'b1;
    m_axis_tready      = '1;
    for (int i = 0; i < 6; i++) begin
      core_m_axis_tdata = 32'h100 + i;
      #1;
      chk($sformatf("drain%0d", i), m_axis_tvalid, 4'b0001 << heads[i]);
      step_check("drain_model");
    end

    // alternating single-beat requesters 0 and 2
    do_reset(0);
    s_axis_tvalid      = 4'b0101;
    core_s_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_grant", s_axis_tready, (i % 2 == 0) ? 4'b0001 : 4'b0100);
      step_check("alt_model");
    end
    idle_inputs();
    core_m_axis_tvalid = 1'b1;
    m_axis_tready      = '1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_ret", m_axis_tvalid, (i % 2 == 0) ? 4'b0001 : 4'b0100);
      step_check("alt_ret_model");
    end

    // 3-beat packet from requester 1 stays contiguous
    do_reset(0);
    core_s_axis_tready = 1'b1;
    s_axis_tvalid      = 4'b0001;
    step_check("pkt_pre");
    s_axis_tvalid = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      s_axis_tlast = (i == 2) ? 4'b1111 : 4'b1101;
      #1;
      chk("pkt_lock", {s_axis_tready, core_s_axis_tlast}, {4'b0010, (i == 2)});
      step_check("pkt_model");
    end
    #1;
    chk("pkt_rr_next", s_axis_tready, 4'b0100);
    step_check("pkt_after");

    // result path stalled: FIFO fills at exactly D beats
    do_reset(0);
    s_axis_tvalid      = 4'b0001;
    core_s_axis_tready = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (s_axis_tready[0]) acc++;
      step_check("full_model");
    end
    chk("full_count", acc, D);
    core_m_axis_tvalid = 1'b1;
    step_check("full_stall");
    m_axis_tready = 4'b0001;
    #1;
    chk("full_pop_no_push", s_axis_tready, 4'b0000);
    step_check("full_pop");
    m_axis_tready      = '0;
    core_m_axis_tvalid = 1'b0;
    #1;
    chk("full_reopen", s_axis_tready, 4'b0001);
    step_check("full_reopen_model");

    // orphan result with empty FIFO
    do_reset(0);
    core_m_axis_tvalid = 1'b1;
    core_m_axis_tdata  = 32'h0000_0005;
    m_axis_tready      = '1;
    #1;
    chk("orph_drop", {m_axis_tvalid, core_m_axis_tready}, {4'b0000, 1'b1});
    step_check("orph_model");
    core_m_axis_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) step_check("orph_sticky");
    chk("orph_set", arb_orphan_o, 1'b1);
    do_reset(1);

    // reset while locked on requester 3 with tags in flight
    do_reset(0);
    s_axis_tvalid      = 4'b1000;
    s_axis_tlast       = 4'b0000;
    core_s_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) step_check("lock3_model");
    chk("lock3_busy", arb_busy_o, 1'b1);
    do_reset(0);
    s_axis_tvalid      = 4'b1111;
    core_s_axis_tready = 1'b1;
    #1;
    chk("lock3_rr0", s_axis_tready, 4'b0001);
    step_check("lock3_after");

`ifdef VEC_MAG_ARB_STATS_EN
    do_reset(0);
    core_s_axis_tready = 1'b1;
    s_axis_tvalid      = 4'b0010;
    for (int i = 0; i < 5; i++) step_check("stat_r1");
    s_axis_tvalid = 4'b1000;
    for (int i = 0; i < 2; i++) step_check("stat_r3");
    chk("stat_cnt", arb_grant_cnt_o, {32'd2, 32'd0, 32'd5, 32'd0});
`endif

    do_reset(0);
    for (int c = 0; c < 3000; c++) begin
      s_axis_tvalid = 4'($urandom);
      s_axis_tlast  = 4'($urandom) | 4'($urandom);
      for (int i = 0; i < N; i++) s_axis_tdata[i*BW +: BW] = $urandom;
      core_s_axis_tready = ($urandom_range(0, 3) != 0);
      core_m_axis_tvalid = ($urandom_range(0, 2) != 0);
      core_m_axis_tdata  = $urandom;
      m_axis_tready      = 4'($urandom);
      step_check("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
